ex_addsub_pipe: RTL
===================

Name: ex_addsub_pipe

Overview:
Two-stage pipelined 32-bit add/subtract unit for the execute stage of the five-stage processor.
- Stage 1 (upstream of the 32-bit carry-lookahead tree lac5) forms and registers generate/propagate vectors from the operands.
- Stage 2 (downstream of lac5) consumes the carry vector, forms sum and flags, and holds the result.
- Valid/ready handshakes on both sides; full throughput of one op per cycle.

Parameters:
DATA_W, 32, operand/result width; must remain 32 (lac5 is fixed-width); any other value is a configuration error.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset: asynchronous assert, active-low
in_valid  in  1  operand beat valid
in_ready  out  1  unit can accept operand beat this cycle
in_a  in  32  operand A
in_b  in  32  operand B
in_sub  in  1  1 = A - B, 0 = A + B
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts result this cycle
out_sum  out  32  result
out_cout  out  1  carry out (for subtract: 1 = no borrow)
out_ovf  out  1  signed overflow
out_zero  out  1  result == 0
out_neg  out  1  out_sum[31]

Behaviour:
- Reset: s1_valid=0, out_valid=0. All data registers (stage-1 g/p/cin/sign bits, out_sum, out_cout, out_ovf, out_zero, out_neg) = 0. Takes effect immediately on rst_n low, not waiting for clk. in_ready = 1 the first cycle after release.
- Operand transform: bx = in_sub ? ~in_b : in_b; g = in_a & bx; p = in_a ^ bx; cin = in_sub.
- Stage 1 register holds g, p, cin, in_a[31], bx[31], plus s1_valid.
- Stage 2: one lac5 instance, Cin=cin_s1, g=g_s1, p=p_s1.
  - c[i] is the carry into bit i; c[0] = Cin.
  - sum[i] = p_s1[i] ^ c[i].
  - cout = gout | (pout & cin_s1).
  - ovf = c[31] ^ cout.
  - zero = (sum == 0); neg = sum[31].
  - All registered into the output register.
- Advance rules:
  - s2_adv = s1_valid & (!out_valid | out_ready).
  - s1_adv = in_valid & in_ready.
  - in_ready = !s1_valid | s2_adv. Combinational from out_ready; no combinational path from in_valid.
- Register updates:
  - On s2_adv: output register loads and out_valid <= 1.
  - Else if out_ready: out_valid <= 0.
  - s1_valid <= s1_adv | (s1_valid & !s2_adv).
- Latency: result visible 2 cycles after the accepting edge when unstalled.
- Simultaneous accept-in and drain-out in the same cycle is legal and loses no beat.
- Stall: out_valid=1 and out_ready=0 hold out_* stable. Stage 1 may still fill once; then in_ready=0. Maximum two beats in flight.
- Output stability: out_* change only on a new beat load; when out_valid=0 they retain the last values.
- Inputs are ignored when in_valid=0 or in_ready=0.
- Reset mid-operation: all in-flight beats discarded, no partial output.
- Wrap-around: 0xFFFFFFFF + 1 = 0 with cout=1, modulo 2^32.

Optional Feature:
Macro ADDSUB_SAT_EN.
- Defined:
  - Extra input port in_sat (1 bit), registered alongside stage 1.
  - When sat_s1=1 and ovf=1: out_sum = 0x7FFFFFFF if in_a[31]==0, else 0x80000000.
  - out_zero/out_neg reflect the clamped value; out_ovf still reports 1.
- Undefined: no in_sat port; out_sum is always the wrapped result.

Test Plan:
- Reset: rst_n low mid-stream with 2 beats in flight -> out_valid=0 and outputs 0 without a clk edge; after release in_ready=1 and no stale beat emerges.
- Add: a=0x00000005, b=0x00000003, sub=0, out_ready=1 -> 2 cycles later out_sum=0x00000008, cout=0, ovf=0, zero=0, neg=0.
- Subtract: a=0x00000003, b=0x00000003, sub=1 -> sum=0x00000000, cout=1, zero=1. Then a=0, b=1, sub=1 -> sum=0xFFFFFFFF, cout=0, neg=1.
- Overflow/wrap: a=0x7FFFFFFF, b=1, add -> sum=0x80000000, ovf=1, cout=0. a=0xFFFFFFFF, b=1 -> sum=0, cout=1, ovf=0. With ADDSUB_SAT_EN and in_sat=1, the first case gives 0x7FFFFFFF, ovf=1.
- Backpressure: stream 4 beats with out_ready=0 for 5 cycles -> in_ready drops after 2 accepted; out_sum stable; on release all 4 results delivered in order, none dropped or duplicated.
- Throughput: continuous in_valid=1, out_ready=1 for 100 random beats -> one result per cycle, each matching the reference model, with a 2-cycle offset.

Source files
------------

// File: rtl/ex_addsub_pipe_if.sv
// Operand/result handshake bundle for ex_addsub_pipe; in_sat exists only when ADDSUB_SAT_EN is defined.
interface ex_addsub_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
`ifdef ADDSUB_SAT_EN
  logic        in_sat;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic        out_zero;
  logic        out_neg;

`ifdef ADDSUB_SAT_EN
  modport master (
    output in_valid, in_a, in_b, in_sub, in_sat, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_sat, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );
  modport slave (
    input  in_valid, in_a, in_b, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero, out_neg
  );
`endif
endinterface

// File: rtl/ex_addsub_pipe.sv
// Two-stage pipelined 32-bit add/subtract with a 5-level carry-lookahead tree (lac5) between stages.
// Optional signed saturation is enabled by defining ADDSUB_SAT_EN.
module ex_addsub_lac5 (
  input  logic        cin,
  input  logic [31:0] g,
  input  logic [31:0] p,
  output logic [31:0] c,
  output logic        gout,
  output logic        pout
);
  // Kogge-Stone prefix: after level 5, gt[5][i]/pt[5][i] cover bits [i:0]
  logic [31:0] gt [0:5];
  logic [31:0] pt [0:5];

  assign gt[0] = g;
  assign pt[0] = p;

  genvar gi;
  generate
    for (gi = 1; gi <= 5; gi++) begin : g_level
      localparam int D = 1 << (gi - 1);
      assign gt[gi] = gt[gi-1] | (pt[gi-1] & {gt[gi-1][31-D:0], {D{1'b0}}});
      assign pt[gi] = pt[gi-1] & {pt[gi-1][31-D:0], {D{1'b1}}};
    end
  endgenerate

  assign c    = {gt[5][30:0] | (pt[5][30:0] & {31{cin}}), cin};
  assign gout = gt[5][31];
  assign pout = pt[5][31];
endmodule

module ex_addsub_pipe #(
  parameter int DATA_W = 32
) (
  input logic             clk,
  input logic             rst_n,
  ex_addsub_pipe_if.slave bus
);
  generate
    if (DATA_W != 32) begin : g_bad_width
      $error("ex_addsub_pipe: DATA_W must be 32");
    end
  endgenerate

  logic [31:0] bx;
  logic        s1_adv, s2_adv;
  logic        s1_valid_q, s1_valid_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] g_q, p_q;
  logic        cin_q, a31_q, b31_q;
`ifdef ADDSUB_SAT_EN
  logic        sat_q;
`endif
  logic [31:0] carry, raw_sum, res_sum;
  logic        gout, pout, cout, ovf;
  logic [31:0] sum_q;
  logic        cout_q, ovf_q, zero_q, neg_q;

  assign bx = bus.in_sub ? ~bus.in_b : bus.in_b;

  // in_ready depends on out_ready but never on in_valid
  assign s2_adv       = s1_valid_q & (~out_valid_q | bus.out_ready);
  assign bus.in_ready = ~s1_valid_q | s2_adv;
  assign s1_adv       = bus.in_valid & bus.in_ready;
  assign s1_valid_d   = s1_adv | (s1_valid_q & ~s2_adv);

  always_comb begin
    out_valid_d = out_valid_q;
    if (s2_adv) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      g_q        <= '0;
      p_q        <= '0;
      cin_q      <= 1'b0;
      a31_q      <= 1'b0;
      b31_q      <= 1'b0;
`ifdef ADDSUB_SAT_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_adv) begin
        g_q   <= bus.in_a & bx;
        p_q   <= bus.in_a ^ bx;
        cin_q <= bus.in_sub;
        a31_q <= bus.in_a[31];
        b31_q <= bx[31];
`ifdef ADDSUB_SAT_EN
        sat_q <= bus.in_sat;
`endif
      end
    end
  end

  ex_addsub_lac5 u_lac5 (
    .cin  (cin_q),
    .g    (g_q),
    .p    (p_q),
    .c    (carry),
    .gout (gout),
    .pout (pout)
  );

  assign raw_sum = p_q ^ carry;
  assign cout    = gout | (pout & cin_q);
  assign ovf     = carry[31] ^ cout;

`ifdef ADDSUB_SAT_EN
  // Clamp toward the sign of A: overflow only happens when A and B' share a sign
  assign res_sum = (sat_q && ovf) ? (a31_q ? 32'h8000_0000 : 32'h7FFF_FFFF) : raw_sum;
`else
  assign res_sum = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s2_adv) begin
        sum_q  <= res_sum;
        cout_q <= cout;
        ovf_q  <= ovf;
        zero_q <= (res_sum == 32'h0);
        neg_q  <= res_sum[31];
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;
  assign bus.out_zero  = zero_q;
  assign bus.out_neg   = neg_q;

  // p[31] must always equal the registered sign bits of A and B'
  sign_bits_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    s1_valid_q |-> (p_q[31] == (a31_q ^ b31_q)));
endmodule
